// File: rtl/freq_meter.sv
// Reference-clock frequency meter: counts synchronized rising edges of sig_in over a window of
// ref_clk cycles and checks the count against a target. Optional FREQ_METER_AVG_EN: 4-window average.
module freq_meter #(
  parameter int unsigned CNT_W       = 16,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned TOL         = 4
) (
  input  logic             ref_clk,
  input  logic             reset,
  input  logic             sig_in,
  input  logic             start,
  input  logic             cont,
  input  logic [CNT_W-1:0] ref_counter,
  input  logic [CNT_W-1:0] counter,
  output logic             busy,
  output logic             valid,
  output logic [CNT_W-1:0] count,
  output logic [2:0]       status
);

  localparam logic [CNT_W-1:0] CntMax = '1;
  localparam logic [CNT_W-1:0] CntOne = CNT_W'(1);
  localparam logic [CNT_W:0]   TolW   = (CNT_W+1)'(TOL);

  typedef enum logic [1:0] {StIdle, StArm, StMeas, StDone} state_e;

  state_e                   state_q, state_d;
  logic [SYNC_STAGES-1:0]   sync_q;
  logic                     hist_q;
  logic                     edge_det;
  logic [CNT_W-1:0]         win_len_q, win_len_d;
  logic [CNT_W-1:0]         target_q, target_d;
  logic [CNT_W-1:0]         win_cnt_q, win_cnt_d;
  logic [CNT_W-1:0]         edge_cnt_q, edge_cnt_d;
  logic                     sat_q, sat_d;
  logic [CNT_W-1:0]         count_q, count_d;
  logic [2:0]               status_q, status_d;

  // Result of the window that finishes this cycle.
  logic                     win_done;
  logic [CNT_W-1:0]         win_count;
  logic                     win_err;
  logic [CNT_W-1:0]         edge_next;
  logic                     sat_next;

`ifdef FREQ_METER_AVG_EN
  logic [3:0][CNT_W-1:0]    avg_hist_q, avg_hist_d;
  logic [3:0]               avg_sat_q, avg_sat_d;
  logic [2:0]               nwin_q, nwin_d;
  logic                     avg_ok_q, avg_ok_d;
  logic [CNT_W+1:0]         avg_sum;
`endif

  function automatic logic [2:0] calc_status(logic [CNT_W-1:0] cnt, logic [CNT_W-1:0] tgt,
                                             logic err);
    logic [CNT_W:0] diff;
    if (cnt >= tgt) diff = {1'b0, cnt} - {1'b0, tgt};
    else            diff = {1'b0, tgt} - {1'b0, cnt};
    if (err)                return 3'b100;
    else if (diff <= TolW)  return 3'b001;
    else                    return 3'b010;
  endfunction

  assign edge_det = sync_q[SYNC_STAGES-1] & ~hist_q;

  always_comb begin
    state_d    = state_q;
    win_len_d  = win_len_q;
    target_d   = target_q;
    win_cnt_d  = win_cnt_q;
    edge_cnt_d = edge_cnt_q;
    sat_d      = sat_q;
    count_d    = count_q;
    status_d   = status_q;
    win_done   = 1'b0;
    win_count  = '0;
    win_err    = 1'b0;
    edge_next  = edge_cnt_q;
    sat_next   = sat_q;
`ifdef FREQ_METER_AVG_EN
    avg_hist_d = avg_hist_q;
    avg_sat_d  = avg_sat_q;
    nwin_d     = nwin_q;
    avg_ok_d   = avg_ok_q;
    avg_sum    = '0;
`endif

    unique case (state_q)
      StIdle: begin
        if (start) begin
          win_len_d = ref_counter;
          target_d  = counter;
          state_d   = StArm;
        end
      end
      StArm: begin
        edge_cnt_d = '0;
        sat_d      = 1'b0;
        win_cnt_d  = win_len_q;
        if (win_len_q == '0) begin
          // Zero-length window reports an error with an empty count.
          win_done = 1'b1;
          win_err  = 1'b1;
          state_d  = StDone;
        end else begin
          state_d = StMeas;
        end
      end
      StMeas: begin
        if (edge_det && (edge_cnt_q != CntMax)) edge_next = edge_cnt_q + CntOne;
        if (edge_next == CntMax) sat_next = 1'b1;
        edge_cnt_d = edge_next;
        sat_d      = sat_next;
        win_cnt_d  = win_cnt_q - CntOne;
        if (win_cnt_q == CntOne) begin
          win_done  = 1'b1;
          win_count = edge_next;
          win_err   = sat_next;
          state_d   = StDone;
        end
      end
      StDone: begin
        state_d = cont ? StArm : StIdle;
      end
      default: state_d = StIdle;
    endcase

`ifdef FREQ_METER_AVG_EN
    if ((state_q == StIdle) && (state_d == StArm)) begin
      avg_hist_d = '0;
      avg_sat_d  = '0;
      nwin_d     = '0;
      avg_ok_d   = 1'b0;
    end
    if (win_done) begin
      avg_hist_d = {avg_hist_q[2:0], win_count};
      avg_sat_d  = {avg_sat_q[2:0], win_err};
      nwin_d     = (nwin_q == 3'd4) ? 3'd4 : nwin_q + 3'd1;
      avg_sum    = {2'b00, avg_hist_d[0]} + {2'b00, avg_hist_d[1]} +
                   {2'b00, avg_hist_d[2]} + {2'b00, avg_hist_d[3]};
      avg_ok_d   = (nwin_d == 3'd4);
      if (nwin_d == 3'd4) begin
        count_d  = avg_sum[CNT_W+1:2];
        status_d = calc_status(avg_sum[CNT_W+1:2], target_q, |avg_sat_d);
      end
    end
    valid = (state_q == StDone) && avg_ok_q;
`else
    if (win_done) begin
      count_d  = win_count;
      status_d = calc_status(win_count, target_q, win_err);
    end
    valid = (state_q == StDone);
`endif
  end

  always_ff @(posedge ref_clk) begin
    if (reset) begin
      state_q    <= StIdle;
      sync_q     <= '0;
      hist_q     <= 1'b0;
      win_len_q  <= '0;
      target_q   <= '0;
      win_cnt_q  <= '0;
      edge_cnt_q <= '0;
      sat_q      <= 1'b0;
      count_q    <= '0;
      status_q   <= '0;
`ifdef FREQ_METER_AVG_EN
      avg_hist_q <= '0;
      avg_sat_q  <= '0;
      nwin_q     <= '0;
      avg_ok_q   <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      sync_q     <= {sync_q[SYNC_STAGES-2:0], sig_in};
      hist_q     <= sync_q[SYNC_STAGES-1];
      win_len_q  <= win_len_d;
      target_q   <= target_d;
      win_cnt_q  <= win_cnt_d;
      edge_cnt_q <= edge_cnt_d;
      sat_q      <= sat_d;
      count_q    <= count_d;
      status_q   <= status_d;
`ifdef FREQ_METER_AVG_EN
      avg_hist_q <= avg_hist_d;
      avg_sat_q  <= avg_sat_d;
      nwin_q     <= nwin_d;
      avg_ok_q   <= avg_ok_d;
`endif
    end
  end

  assign busy   = (state_q != StIdle);
  assign count  = count_q;
  assign status = status_q;

endmodule
